// File: rtl/btn_irq_ctrl.sv
// -----------------------------------------------------------------------------
// btn_irq_ctrl
//   Conditions a raw push-button into a level interrupt for the SoC: the pad
//   level is synchronised, debounced, edge-detected, and events are queued in
//   a saturating pending counter.  The interrupt request is held until the SoC
//   acknowledges it; an optional holdoff keeps irq_o low for a while after
//   every acknowledge.
//
// Ports
//   clk_i        system clock (clk_gen domain)
//   rst_i        synchronous active-high reset
//   btn_i        raw asynchronous button level, 1 = pressed
//   enable_i     1 = accept new events, 0 = drop new events (pending kept)
//   edge_sel_i   00 none, 01 rising, 10 falling, 11 both
//   irq_ack_i    single-cycle acknowledge from the SoC
//   clr_ovf_i    clears overflow_o
//   irq_o        interrupt request to the SoC
//   btn_level_o  debounced button level
//   pending_o    queued, unacknowledged events
//   overflow_o   sticky: an event was lost because pending_o was saturated
// -----------------------------------------------------------------------------
module btn_irq_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLDOFF_CYCLES  = 0,
  parameter int CNT_WIDTH       = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 btn_i,
  input  logic                 enable_i,
  input  logic [1:0]           edge_sel_i,
  input  logic                 irq_ack_i,
  input  logic                 clr_ovf_i,
  output logic                 irq_o,
  output logic                 btn_level_o,
  output logic [CNT_WIDTH-1:0] pending_o,
  output logic                 overflow_o
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HO_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF_CYCLES);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ASSERT  = 2'd1;
  localparam logic [1:0] S_HOLDOFF = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   btn_s;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   level_q, level_d;
  logic                   level_dly_q, level_dly_d;
  logic                   ev_q, ev_d;
  logic                   rise_s, fall_s;
  logic [CNT_WIDTH-1:0]   pend_q, pend_d;
  logic                   ovf_q, ovf_d;
  logic                   take_s, dec_s, new_ovf_s;
  logic [1:0]             state_q, state_d;
  logic [HO_W-1:0]        timer_q, timer_d;
  logic                   irq_q, irq_d;

  // Synchroniser shift chain; the last stage is the clean button level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_i};
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

  // Debounce: accept a new level only after it has differed from the current
  // one for DEBOUNCE_CYCLES consecutive cycles; any glitch back restarts.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = db_cnt_q;
    if (btn_s == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      level_d  = btn_s;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Edge detection on the debounced level; the event is registered so it is
  // valid one cycle after the level changes.
  always_comb begin
    level_dly_d = level_q;
    rise_s      = level_q & ~level_dly_q;
    fall_s      = ~level_q & level_dly_q;
    case (edge_sel_i)
      2'b01:   ev_d = rise_s;
      2'b10:   ev_d = fall_s;
      2'b11:   ev_d = rise_s | fall_s;
      default: ev_d = 1'b0;
    endcase
  end

  // Saturating pending counter and sticky overflow; a fresh overflow beats a
  // simultaneous clear so the loss is never hidden.
  always_comb begin
    take_s    = ev_q & enable_i;
    dec_s     = irq_ack_i & irq_q;
    new_ovf_s = take_s & ~dec_s & (pend_q == {CNT_WIDTH{1'b1}});
    pend_d    = pend_q;
    if (take_s && !dec_s) begin
      if (new_ovf_s) begin
        pend_d = pend_q;
      end else begin
        pend_d = pend_q + CNT_WIDTH'(1);
      end
    end else if (!take_s && dec_s) begin
      pend_d = pend_q - CNT_WIDTH'(1);
    end else begin
      pend_d = pend_q;
    end
    if (new_ovf_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // IRQ FSM; irq_d is decoded from the next state so irq_o is a flop output.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (pend_q != '0) begin
          state_d = S_ASSERT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ASSERT: begin
        if (dec_s) begin
          if (HOLDOFF_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLDOFF;
            timer_d = HO_LOAD;
          end
        end else begin
          state_d = S_ASSERT;
        end
      end
      S_HOLDOFF: begin
        if (timer_q <= HO_W'(1)) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - HO_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
    irq_d = (state_d == S_ASSERT);
  end

  // State registers with synchronous reset; reset drops every pending event.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q      <= '0;
      db_cnt_q    <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      ev_q        <= 1'b0;
      pend_q      <= '0;
      ovf_q       <= 1'b0;
      state_q     <= S_IDLE;
      timer_q     <= '0;
      irq_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      db_cnt_q    <= db_cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      ev_q        <= ev_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      irq_q       <= irq_d;
    end
  end

  assign irq_o       = irq_q;
  assign btn_level_o = level_q;
  assign pending_o   = pend_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_btn_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_btn_irq_ctrl
//   Directed bench for btn_irq_ctrl with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
//   HOLDOFF_CYCLES=3, CNT_WIDTH=2.  Inputs are driven and outputs sampled 1ns
//   after each rising clock edge.  A clean button change becomes visible on
//   btn_level_o 6 edges later (2 sync + 4 debounce) and on pending_o 2 edges
//   after that.
// -----------------------------------------------------------------------------
module tb_btn_irq_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       btn_i = 1'b0;
  logic       enable_i = 1'b1;
  logic [1:0] edge_sel_i = 2'b01;
  logic       irq_ack_i = 1'b0;
  logic       clr_ovf_i = 1'b0;
  logic       irq_o;
  logic       btn_level_o;
  logic [1:0] pending_o;
  logic       overflow_o;

  int tests_run = 0;
  int tests_failed = 0;

  btn_irq_ctrl #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .HOLDOFF_CYCLES (3),
    .CNT_WIDTH      (2)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .btn_i      (btn_i),
    .enable_i   (enable_i),
    .edge_sel_i (edge_sel_i),
    .irq_ack_i  (irq_ack_i),
    .clr_ovf_i  (clr_ovf_i),
    .irq_o      (irq_o),
    .btn_level_o(btn_level_o),
    .pending_o  (pending_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Clean level change, long enough for debounce plus event bookkeeping.
  task automatic set_btn(input logic v);
    btn_i = v;
    tick(8);
  endtask

  task automatic ack_pulse();
    irq_ack_i = 1'b1;
    tick(1);
    irq_ack_i = 1'b0;
  endtask

  // Bounded wait for irq_o to rise; a timeout shows up as a failed check.
  task automatic wait_irq(input string tag);
    int n = 0;
    while (irq_o !== 1'b1 && n < 12) begin
      tick(1);
      n++;
    end
    check_eq(tag, irq_o, 1);
  endtask

  task automatic drain(input int events);
    for (int k = 0; k < events; k++) begin
      wait_irq("drain_irq");
      ack_pulse();
    end
    tick(6);
    check_eq("drain_pending", pending_o, 0);
  endtask

  initial begin
    // 1. Reset with button held, then the held press produces one event.
    btn_i = 1'b1;
    tick(2);
    check_eq("rst_irq", irq_o, 0);
    check_eq("rst_level", btn_level_o, 0);
    check_eq("rst_pending", pending_o, 0);
    check_eq("rst_ovf", overflow_o, 0);
    rst_i = 1'b0;
    tick(5);
    check_eq("rst_level_early", btn_level_o, 0);
    tick(1);
    check_eq("rst_level_rise", btn_level_o, 1);
    tick(2);
    check_eq("rst_pending_n2", pending_o, 1);
    check_eq("rst_irq_n2", irq_o, 0);
    tick(1);
    check_eq("rst_irq_n3", irq_o, 1);
    ack_pulse();
    check_eq("ack1_irq", irq_o, 0);
    check_eq("ack1_pending", pending_o, 0);
    tick(6);
    check_eq("idle_irq", irq_o, 0);

    // 2. Bounce: 2-cycle pulses never reach 4 stable cycles.
    set_btn(1'b0);
    check_eq("release_level", btn_level_o, 0);
    check_eq("release_no_event", pending_o, 0);
    for (int i = 0; i < 2; i++) begin
      btn_i = 1'b1;
      tick(2);
      btn_i = 1'b0;
      tick(2);
    end
    tick(2);
    check_eq("bounce_level", btn_level_o, 0);
    check_eq("bounce_pending", pending_o, 0);
    set_btn(1'b1);
    check_eq("bounce_final_level", btn_level_o, 1);
    tick(4);
    check_eq("bounce_one_event", pending_o, 1);
    check_eq("bounce_irq", irq_o, 1);
    drain(1);

    // 3. Handshake with a second event queued: holdoff then re-assert.
    set_btn(1'b0);
    set_btn(1'b1);
    set_btn(1'b0);
    set_btn(1'b1);
    check_eq("hs_pending2", pending_o, 2);
    check_eq("hs_irq", irq_o, 1);
    ack_pulse();
    check_eq("hs_ack_irq", irq_o, 0);
    check_eq("hs_ack_pending", pending_o, 1);
    tick(1);
    check_eq("hs_hold1", irq_o, 0);
    tick(1);
    check_eq("hs_hold2", irq_o, 0);
    wait_irq("hs_reassert");
    check_eq("hs_reassert_pending", pending_o, 1);
    drain(1);

    // 4. Saturation at 3, overflow on the 4th press, then clear.
    for (int i = 0; i < 3; i++) begin
      set_btn(1'b0);
      set_btn(1'b1);
    end
    check_eq("sat_pending3", pending_o, 3);
    check_eq("sat_no_ovf_yet", overflow_o, 0);
    set_btn(1'b0);
    set_btn(1'b1);
    check_eq("sat_pending_hold", pending_o, 3);
    check_eq("sat_ovf", overflow_o, 1);
    clr_ovf_i = 1'b1;
    tick(1);
    clr_ovf_i = 1'b0;
    check_eq("clr_ovf", overflow_o, 0);
    check_eq("clr_pending", pending_o, 3);
    drain(3);

    // 5. Ack and new event in the same cycle with one pending.
    set_btn(1'b0);
    set_btn(1'b1);
    tick(1);
    check_eq("sim_irq", irq_o, 1);
    set_btn(1'b0);
    btn_i = 1'b1;
    tick(7);
    check_eq("sim_pre_pending", pending_o, 1);
    ack_pulse();
    check_eq("sim_pending", pending_o, 1);
    check_eq("sim_irq_low", irq_o, 0);
    tick(2);
    check_eq("sim_hold", irq_o, 0);
    wait_irq("sim_reassert");
    drain(1);

    // 6. Edge selection and enable.
    set_btn(1'b0);
    edge_sel_i = 2'b10;
    set_btn(1'b1);
    check_eq("fall_press", pending_o, 0);
    set_btn(1'b0);
    check_eq("fall_release", pending_o, 1);
    drain(1);
    edge_sel_i = 2'b11;
    set_btn(1'b1);
    set_btn(1'b0);
    check_eq("both_pending", pending_o, 2);
    drain(2);
    enable_i = 1'b0;
    set_btn(1'b1);
    set_btn(1'b0);
    check_eq("dis_pending", pending_o, 0);
    check_eq("dis_irq", irq_o, 0);
    enable_i = 1'b1;

    // Reset in the middle of an active request discards pending events.
    set_btn(1'b1);
    tick(1);
    check_eq("mid_irq", irq_o, 1);
    rst_i = 1'b1;
    tick(1);
    check_eq("mid_rst_irq", irq_o, 0);
    check_eq("mid_rst_pending", pending_o, 0);
    rst_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/btn_irq_ctrl.md
Name: btn_irq_ctrl

Overview:
Conditions the raw push-button interrupt source before it reaches the sigma SoC irq_btn_i input. Synchronises and debounces the button, detects configurable edges, queues events in a saturating pending counter, and drives a level IRQ with request/acknowledge handshake and post-ack holdoff. Sits in the board top between the pad and the SoC, in the clk_gen domain.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on btn_i (min 2)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (min 1)
HOLDOFF_CYCLES, 0, idle cycles forced after each ack before irq_o may re-assert (0 = none)
CNT_WIDTH, 4, width of pending event counter

Ports:
clk_i  input  1  system clock (clk_gen)
rst_i  input  1  synchronous active-high reset
btn_i  input  1  raw asynchronous button level (1 = pressed)
enable_i  input  1  1 = accept new events; 0 = drop new events, keep pending
edge_sel_i  input  2  00 none, 01 rising, 10 falling, 11 both
irq_ack_i  input  1  single-cycle acknowledge from SoC
clr_ovf_i  input  1  clears overflow_o
irq_o  output  1  interrupt request to SoC
btn_level_o  output  1  debounced button level
pending_o  output  CNT_WIDTH  queued unacknowledged events
overflow_o  output  1  sticky: event lost at saturation

Behaviour:
- Reset (rst_i=1 at clk_i edge): sync chain, btn_level_o, debounce counter, pending_o, overflow_o, irq_o all 0; FSM -> IDLE. Reset mid-IRQ discards all pending events.
- Sync: btn_i through SYNC_STAGES flops; output = btn_s.
- Debounce: if btn_s == btn_level_o, counter cleared. Else counter increments; when counter reaches DEBOUNCE_CYCLES-1 and btn_s still differs, btn_level_o <= btn_s and counter cleared. Any glitch back to btn_level_o restarts the count.
- Button held through reset release: btn_level_o starts 0, so a rising edge is produced after debounce (intended).
- Edge event ev: registered btn_level_o vs. its 1-cycle delayed copy, qualified by edge_sel_i; ev valid in cycle N+1 when btn_level_o changes at N.
- Pending counter (per cycle, take = ev & enable_i, dec = irq_ack_i & irq_o):
  - take & !dec: +1; if already all-ones, hold and set overflow_o.
  - !take & dec: -1 (pending ≥1 guaranteed while irq_o=1).
  - take & dec: unchanged.
  - clr_ovf_i clears overflow_o; simultaneous new overflow wins (stays 1).
- FSM (irq_o registered):
  - IDLE: irq_o=0; pending_o != 0 -> ASSERT (irq_o=1 next cycle).
  - ASSERT: irq_o=1; on dec -> HOLDOFF with timer=HOLDOFF_CYCLES, or -> IDLE if HOLDOFF_CYCLES=0; irq_o=0 the cycle after ack.
  - HOLDOFF: irq_o=0; timer decrements; at 1 -> IDLE. Events still counted.
- irq_ack_i while irq_o=0: ignored, no counter change.
- Latency: btn_level_o change at N -> pending_o +1 at N+2 -> irq_o=1 at N+3.
- enable_i=0 does not mask irq_o for already pending events.
- edge_sel_i changes take effect next cycle; no spurious event generated.

Test Plan:
(Params: DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=3, CNT_WIDTH=2, edge_sel_i=01, enable_i=1 unless noted.)
1. Reset: assert rst_i 2 cycles with btn_i=1 -> all outputs 0; after release, btn_level_o=1 after SYNC_STAGES+4 cycles; irq_o=1 3 cycles later, pending_o=1.
2. Bounce: btn_i toggles 1,0,1,0 each 2 cycles then holds 1 -> btn_level_o rises only after 4 stable cycles; exactly one event, pending_o=1.
3. Handshake: irq_o=1, pulse irq_ack_i -> next cycle irq_o=0, pending_o=0; with second event queued (pending_o=2 before ack) -> irq_o stays 0 for 3 holdoff cycles then re-asserts, pending_o=1.
4. Saturation: 4 debounced presses without ack -> pending_o=3, overflow_o=1; clr_ovf_i pulse -> overflow_o=0, pending_o=3.
5. Simultaneous ack and event with pending_o=1 -> pending_o stays 1, FSM enters HOLDOFF, irq_o re-asserts after 3 cycles.
6. Config: edge_sel_i=10, press and release -> one event on release only; edge_sel_i=11 -> two events; enable_i=0 -> pending_o unchanged, irq_o stays 0.
